serial_frame_rx_ctrl: RTL
=========================

Name: serial_frame_rx_ctrl

Overview:
Receive-side controller for the single-wire serial byte link. It samples one bit per clock and sequences each frame: start bit, DATA_BITS data bits LSB-first, an optional parity bit, then the stop bit. Good bytes go to a valid/ready holding stage for downstream consumers. Framing, parity and overrun events are flagged and counted; after a bad stop bit the block resynchronises to line-idle.

Parameters:
DATA_BITS, 8, data bits per frame (range 5..9)
PARITY_EN, 1, 1 = parity bit present between data and stop
PARITY_ODD, 1, 1 = odd parity, 0 = even parity (ignored if PARITY_EN=0)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
din  in  1  serial line; idle = 1, start = 0, stop = 1
out_data  out  DATA_BITS  received byte; stable while out_valid=1
out_valid  out  1  holding stage contains an unconsumed byte
out_ready  in  1  consumer accepts out_data when out_valid&&out_ready
busy  out  1  state != IDLE
frame_err  out  1  one-cycle pulse: stop bit sampled as 0
parity_err  out  1  one-cycle pulse: stop good, parity mismatch
overrun  out  1  one-cycle pulse: good byte dropped because holding stage full
err_count  out  ERR_CNT_W  saturating count of frame_err+parity_err+overrun events

Behaviour:
- Reset (async, any state, mid-frame included): state=IDLE, bit counter=0, shift reg=0, out_data=0, out_valid=0, busy=0, all pulses=0, err_count=0.
- States: IDLE, DATA, PARITY, STOP, RESYNC.
- IDLE: din=0 -> DATA with bitcnt=0; din=1 -> stay.
- DATA: shift din into bit[bitcnt] (LSB first). After the DATA_BITS-th bit: go to PARITY if PARITY_EN, else STOP.
- PARITY: latch din as the parity bit, then go to STOP.
  - Expected parity = XOR(data) ^ PARITY_ODD.
- STOP, din=1: go to IDLE. A start bit on the very next cycle is accepted, so back-to-back frames need zero idle bits.
  - Parity OK (or PARITY_EN=0): byte is complete.
  - Parity bad: parity_err pulse; byte discarded.
- STOP, din=0: frame_err pulse; byte discarded; go to RESYNC.
- RESYNC: stay while din=0; din=1 -> IDLE. No start bit is detected in RESYNC.
- Latency: start bit sampled at cycle S. Data bits at S+1..S+DATA_BITS, parity at S+DATA_BITS+1, stop at S+DATA_BITS+1+PARITY_EN. All outputs (out_valid rise, error pulses) are registered and appear on the cycle after stop is sampled: S+11 for the default configuration.
- Holding stage, when a complete byte arrives on a cycle:
  - out_valid=0: load the byte, out_valid=1.
  - out_valid=1 and out_ready=1: old byte consumed, new byte loaded, out_valid stays 1.
  - out_valid=1 and out_ready=0: new byte dropped, old byte kept, overrun pulse.
- With no byte arriving, out_valid&&out_ready clears out_valid. out_ready is ignored when out_valid=0.
- err_count: +1 per cycle with any error pulse. At most one pulse can occur per cycle because the error events are mutually exclusive. Saturates at 2^ERR_CNT_W-1; never wraps.
- busy=1 in DATA/PARITY/STOP/RESYNC.

Decomposition:
- Package serial_pkg holds:
  - state enum rx_state_t {IDLE, DATA, PARITY, STOP, RESYNC};
  - default constants SERIAL_DATA_BITS=8, SERIAL_IDLE_LEVEL=1'b1.
- One sub-module, serial_out_buf: a single-entry valid/ready holding register with load/overrun logic. Inputs: load, load_data, out_ready. Outputs: out_data, out_valid, overrun. The FSM, shift register, parity and counter stay in the top module.

Test Plan:
- Reset, then din frame 0,[1,0,1,0,0,1,0,1],par=1(odd),1 with out_ready=1 -> out_data=0xA5, out_valid high exactly 1 cycle at S+11, no error pulses.
- Two back-to-back frames 0x3C then 0xC3 with no idle bit, out_ready=0 -> first byte 0x3C held, overrun pulse at second frame's S+11, err_count=1, out_data stays 0x3C.
- Frame with wrong parity bit for 0x0F -> parity_err pulse at S+11, out_valid stays 0, err_count+1, next frame received normally.
- Stop bit=0, din held 0 for 5 more cycles, then 1, then a 0x55 frame -> frame_err pulse once, busy stays high through RESYNC, 0x55 delivered afterwards.
- Assert reset (reset=0) at data bit 4 of a frame, release, then send 0x81 -> no output from the aborted frame, out_valid=0 and err_count=0 after reset, 0x81 received correctly.
- ERR_CNT_W=2, inject 5 frame errors -> err_count saturates at 3 and stays there.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        RESYNC
    } rx_state_t;

    localparam int   SERIAL_DATA_BITS  = 8;
    localparam logic SERIAL_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_out_buf.sv
// Single-entry valid/ready holding register for received bytes.
// A byte arriving while the entry is full and not being drained is dropped
// and reported with a one-cycle overrun pulse; the held byte is kept.
module serial_out_buf #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 overrun
);

    // Load, replace-on-consume, drop-on-full and drain of the holding entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!out_valid || out_ready) begin
                    out_data  <= load_data;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// Receive-side frame controller for the single-wire serial byte link.
// One line sample per clock: start, DATA_BITS data bits LSB first,
// optional parity, stop. Good bytes go to serial_out_buf.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a start bit (din=0)
//   DATA   | sampling data bits into the shift register, LSB first
//   PARITY | latching the parity bit
//   STOP   | checking the stop bit; byte completes or is discarded here
//   RESYNC | bad stop seen, waiting for the line to return high
module serial_frame_rx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = SERIAL_DATA_BITS,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_t            state;
    logic [CNT_W-1:0]     bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic par_ok;
    logic stop_good;
    logic byte_done;
    logic frame_evt;
    logic parity_evt;
    logic overrun_evt;
    logic any_err;

    // Stop-cycle decisions; these drive both the output stage and the counter.
    always_comb begin
        par_ok      = (PARITY_EN == 0) ||
                      (par_bit == ((^shreg) ^ (PARITY_ODD != 0)));
        stop_good   = (state == STOP) && (din == SERIAL_IDLE_LEVEL);
        byte_done   = stop_good && par_ok;
        frame_evt   = (state == STOP) && (din != SERIAL_IDLE_LEVEL);
        parity_evt  = stop_good && !par_ok;
        overrun_evt = byte_done && out_valid && !out_ready;
        any_err     = frame_evt || parity_evt || overrun_evt;
    end

    // Frame sequencing, shift register, error pulses and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_err  <= frame_evt;
            parity_err <= parity_evt;
            if (any_err && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (din != SERIAL_IDLE_LEVEL) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                end
                DATA: begin
                    shreg[bitcnt] <= din;
                    if (bitcnt == CNT_W'(DATA_BITS - 1)) begin
                        bitcnt <= '0;
                        state  <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                PARITY: begin
                    par_bit <= din;
                    state   <= STOP;
                end
                STOP: begin
                    state <= (din == SERIAL_IDLE_LEVEL) ? IDLE : RESYNC;
                end
                RESYNC: begin
                    if (din == SERIAL_IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    serial_out_buf #(
        .DATA_BITS(DATA_BITS)
    ) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (byte_done),
        .load_data(shreg),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .overrun  (overrun)
    );

endmodule
